// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage access unit with stall handshake; MEM_TIMEOUT_EN adds ack timeout and mem_err
module mem_access_unit #(
  parameter logic [31:0] ADDR_BASE      = 32'd1024,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] Val_Rm_in,
  input  logic        WB_EN_in,
  input  logic        Mem_R_EN_in,
  input  logic        Mem_W_EN_in,
  input  logic [3:0]  dest_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        freeze,
  output logic [31:0] ALU_res,
  output logic [31:0] Mem_res,
  output logic        WB_EN,
  output logic        Mem_R_EN,
`ifdef MEM_TIMEOUT_EN
  output logic        mem_err,
`endif
  output logic [3:0]  dest
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        mem_in;
  logic        done;
  logic        timeout_hit;
  logic [31:0] addr_off;
  logic [31:0] lat_alu;
  logic        lat_wb;
  logic        lat_rd;
  logic [3:0]  lat_dest;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  assign mem_in   = Mem_R_EN_in | Mem_W_EN_in;
  assign addr_off = ALU_res_in - ADDR_BASE;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // The last permitted no-ack cycle is retired as if it were acked.
  assign timeout_hit = (state == ACCESS) && !mem_ack &&
                       (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      if (state != ACCESS)
        wait_cnt <= 8'd0;
      else if (!mem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout_hit)
        mem_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_in) begin
          freeze    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack || timeout_hit) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst)
      freeze = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      ALU_res   <= 32'd0;
      Mem_res   <= 32'd0;
      WB_EN     <= 1'b0;
      Mem_R_EN  <= 1'b0;
      dest      <= 4'd0;
      lat_alu   <= 32'd0;
      lat_wb    <= 1'b0;
      lat_rd    <= 1'b0;
      lat_dest  <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (mem_in) begin
            // A simultaneous read+write request is carried out as a write.
            mem_req   <= 1'b1;
            mem_we    <= Mem_W_EN_in;
            mem_addr  <= addr_off & 32'hFFFF_FFFC;
            mem_wdata <= Val_Rm_in;
            lat_alu   <= ALU_res_in;
            lat_wb    <= WB_EN_in;
            lat_rd    <= Mem_R_EN_in & ~Mem_W_EN_in;
            lat_dest  <= dest_in;
            WB_EN     <= 1'b0;
            Mem_R_EN  <= 1'b0;
            dest      <= 4'd0;
          end else begin
            ALU_res  <= ALU_res_in;
            Mem_res  <= 32'd0;
            WB_EN    <= WB_EN_in;
            Mem_R_EN <= 1'b0;
            dest     <= dest_in;
          end
        end
        ACCESS: begin
          if (done) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            ALU_res  <= lat_alu;
            Mem_res  <= (lat_rd && !timeout_hit) ? mem_rdata : 32'd0;
            WB_EN    <= lat_wb & ~timeout_hit;
            Mem_R_EN <= lat_rd & ~timeout_hit;
            dest     <= lat_dest;
          end else begin
            // Stall cycles present a bubble to write-back.
            WB_EN    <= 1'b0;
            Mem_R_EN <= 1'b0;
            dest     <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (timeout test under MEM_TIMEOUT_EN)
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] ALU_res_in, Val_Rm_in;
  logic        WB_EN_in, Mem_R_EN_in, Mem_W_EN_in;
  logic [3:0]  dest_in;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic [31:0] ALU_res, Mem_res;
  logic        WB_EN, Mem_R_EN;
  logic [3:0]  dest;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  mem_access_unit #(.ADDR_BASE(32'd1024), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ALU_res_in(ALU_res_in), .Val_Rm_in(Val_Rm_in),
    .WB_EN_in(WB_EN_in), .Mem_R_EN_in(Mem_R_EN_in), .Mem_W_EN_in(Mem_W_EN_in),
    .dest_in(dest_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .freeze(freeze),
    .ALU_res(ALU_res), .Mem_res(Mem_res), .WB_EN(WB_EN), .Mem_R_EN(Mem_R_EN),
`ifdef MEM_TIMEOUT_EN
    .mem_err(mem_err),
`endif
    .dest(dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mres;
    logic        wb;
    logic        rd;
    logic [3:0]  dest;
  } wb_rec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rm;
    logic        wb;
    logic [3:0]  dest;
    logic        ack;
    logic [31:0] exp_alu;
    logic        exp_wb;
    logic [3:0]  exp_dest;
  } pt_vec_t;

  wb_rec_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] rm, input logic wb,
                       input logic rd, input logic we, input logic [3:0] d);
    ALU_res_in  = alu;
    Val_Rm_in   = rm;
    WB_EN_in    = wb;
    Mem_R_EN_in = rd;
    Mem_W_EN_in = we;
    dest_in     = d;
  endtask

  // Called just after a negedge: decides retirement from pre-edge freeze, compares after the edge.
  task automatic cycle();
    logic    retire;
    wb_rec_t e;
    #1;
    retire = rst && !freeze;
    @(posedge clk);
    #1;
    if (retire) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ALU_res", ALU_res, e.alu);
        chk("Mem_res", Mem_res, e.mres);
        chk("WB_EN", {31'd0, WB_EN}, {31'd0, e.wb});
        chk("Mem_R_EN", {31'd0, Mem_R_EN}, {31'd0, e.rd});
        chk("dest", {28'd0, dest}, {28'd0, e.dest});
      end
    end
    @(negedge clk);
  endtask

  task automatic push_rec(input logic [31:0] alu, input logic [31:0] mres, input logic wb,
                          input logic rd, input logic [3:0] d);
    wb_rec_t e;
    e.alu = alu; e.mres = mres; e.wb = wb; e.rd = rd; e.dest = d;
    sb.push_back(e);
  endtask

  // Memory instruction acked in its n-th ACCESS cycle (or timing out there when to=1).
  task automatic mem_op(input logic [31:0] alu, input logic [31:0] rm, input logic wb,
                        input logic rd, input logic we, input logic [3:0] d, input int n,
                        input logic [31:0] rdata, input logic [31:0] exp_addr, input bit to);
    logic is_rd;
    is_rd = rd & ~we;
    drive(alu, rm, wb, rd, we, d);
    mem_ack = 1'b0;
    push_rec(alu, (is_rd && !to) ? rdata : 32'd0, wb & ~to, is_rd & ~to, d);
    #1;
    chk("req_before_entry", {31'd0, mem_req}, 32'd0);
    chk("freeze_entry", {31'd0, freeze}, 32'd1);
    cycle();
    for (int k = 1; k <= n; k++) begin
      chk("mem_req_access", {31'd0, mem_req}, 32'd1);
      chk("mem_addr", mem_addr, exp_addr);
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("mem_wdata", mem_wdata, rm);
      mem_ack   = (k == n) && !to;
      mem_rdata = mem_ack ? rdata : $urandom();
      #1;
      chk("freeze_access", {31'd0, freeze}, (k == n) ? 32'd0 : 32'd1);
      cycle();
      mem_ack = 1'b0;
    end
  endtask

  pt_vec_t pt[5];

  initial begin
    pt[0] = '{32'h55,         32'h0,  1'b1, 4'd3,  1'b0, 32'h55,         1'b1, 4'd3};
    pt[1] = '{32'hFFFF_FFFF, 32'h11, 1'b0, 4'd15, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'd15};
    pt[2] = '{32'h1234_5678, 32'h22, 1'b1, 4'd0,  1'b1, 32'h1234_5678, 1'b1, 4'd0};
    pt[3] = '{32'h0,         32'h33, 1'b1, 4'd8,  1'b1, 32'h0,         1'b1, 4'd8};
    pt[4] = '{32'h400,       32'h44, 1'b0, 4'd1,  1'b0, 32'h400,       1'b0, 4'd1};

    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'd0;
    drive(32'd1028, 32'd9, 1'b1, 1'b1, 1'b0, 4'd2);
    @(negedge clk);
    cycle();
    cycle();
    #1;
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_ALU_res", ALU_res, 32'd0);
    chk("rst_Mem_res", Mem_res, 32'd0);
    chk("rst_WB_EN", {31'd0, WB_EN}, 32'd0);
    chk("rst_Mem_R_EN", {31'd0, Mem_R_EN}, 32'd0);
    chk("rst_dest", {28'd0, dest}, 32'd0);
`ifdef MEM_TIMEOUT_EN
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
`endif
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      drive(pt[i].alu, pt[i].rm, pt[i].wb, 1'b0, 1'b0, pt[i].dest);
      mem_ack = pt[i].ack;
      push_rec(pt[i].exp_alu, 32'd0, pt[i].exp_wb, 1'b0, pt[i].exp_dest);
      #1;
      chk("pt_freeze", {31'd0, freeze}, 32'd0);
      cycle();
      chk("pt_mem_req", {31'd0, mem_req}, 32'd0);
    end
    mem_ack = 1'b0;

    mem_op(32'd1028, 32'h0,   1'b1, 1'b1, 1'b0, 4'd2, 3, 32'hDEAD_BEEF, 32'd4, 1'b0);
    mem_op(32'd1030, 32'd7,   1'b0, 1'b0, 1'b1, 4'd4, 1, 32'h0,         32'd4, 1'b0);
    mem_op(32'd2,    32'h5A,  1'b1, 1'b1, 1'b0, 4'd9, 2, 32'h1234_5678, 32'hFFFF_FC00, 1'b0);
    mem_op(32'd2000, 32'hA5A5, 1'b0, 1'b1, 1'b1, 4'd6, 2, 32'hCAFE_F00D, 32'h0000_03D0, 1'b0);

    drive(32'h99, 32'h0, 1'b1, 1'b0, 1'b0, 4'd7);
    push_rec(32'h99, 32'd0, 1'b1, 1'b0, 4'd7);
    cycle();

    drive(32'd1100, 32'hBB, 1'b1, 1'b1, 1'b0, 4'd12);
    cycle();
    chk("mid_req", {31'd0, mem_req}, 32'd1);
    cycle();
    rst = 1'b0;
    #1;
    chk("mid_rst_freeze", {31'd0, freeze}, 32'd0);
    cycle();
    chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
    chk("mid_rst_ALU_res", ALU_res, 32'd0);
    chk("mid_rst_WB_EN", {31'd0, WB_EN}, 32'd0);
    rst = 1'b1;
    drive(32'h77, 32'h0, 1'b1, 1'b0, 1'b0, 4'd5);
    mem_ack = 1'b1;
    push_rec(32'h77, 32'd0, 1'b1, 1'b0, 4'd5);
    #1;
    chk("post_rst_freeze", {31'd0, freeze}, 32'd0);
    cycle();
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    mem_op(32'd1040, 32'h0, 1'b1, 1'b1, 1'b0, 4'd10, 4, 32'h0, 32'd16, 1'b1);
    chk("timeout_mem_err", {31'd0, mem_err}, 32'd1);
    drive(32'h66, 32'h0, 1'b1, 1'b0, 1'b0, 4'd11);
    push_rec(32'h66, 32'd0, 1'b1, 1'b0, 4'd11);
    cycle();
    chk("mem_err_sticky", {31'd0, mem_err}, 32'd1);
`endif

    chk("end_mem_req", {31'd0, mem_req}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
